// File: rtl/ascon_pack.sv
// ASCON-128 shared types and constants: permutation state, IV, round constants
// and round counts.
package ascon_pack;

  // Index k holds state word xk.
  typedef logic [4:0][63:0] ascon_state_t;

  localparam logic [63:0] ASCON_IV  = 64'h80400C0600000000;
  localparam int          PA_ROUNDS = 12;
  localparam int          PB_ROUNDS = 6;

  // Constant for round i of the 12-round schedule; the 6-round schedule uses i = 6..11.
  localparam logic [7:0] RC_TABLE [PA_ROUNDS] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One ASCON permutation round: constant addition, bit-sliced 5-bit S-box, linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  ascon_state_t s_in,
  input  logic [3:0]   rnd,
  output ascon_state_t s_out
);

  logic [7:0]  rc;
  logic [63:0] p0, p1, p2, p3, p4;
  logic [63:0] q0, q1, q2, q3, q4;
  logic [63:0] r0, r1, r2, r3, r4;

  always_comb begin
    // Indices past the table only occur on the idle tag cycle, where the result is unused.
    rc = (rnd < 4'(PA_ROUNDS)) ? RC_TABLE[rnd] : 8'h00;

    p0 = s_in[0] ^ s_in[4];
    p1 = s_in[1];
    p2 = s_in[2] ^ {56'd0, rc} ^ s_in[1];
    p3 = s_in[3];
    p4 = s_in[4] ^ s_in[3];

    q0 = p0 ^ (~p1 & p2);
    q1 = p1 ^ (~p2 & p3);
    q2 = p2 ^ (~p3 & p4);
    q3 = p3 ^ (~p4 & p0);
    q4 = p4 ^ (~p0 & p1);

    r0 = q0 ^ q4;
    r1 = q1 ^ q0;
    r2 = ~q2;
    r3 = q3 ^ q2;
    r4 = q4;

    s_out[0] = r0 ^ ror64(r0, 19) ^ ror64(r0, 28);
    s_out[1] = r1 ^ ror64(r1, 61) ^ ror64(r1, 39);
    s_out[2] = r2 ^ ror64(r2, 1)  ^ ror64(r2, 6);
    s_out[3] = r3 ^ ror64(r3, 10) ^ ror64(r3, 17);
    s_out[4] = r4 ^ ror64(r4, 7)  ^ ror64(r4, 41);
  end

endmodule

// File: rtl/top_level.sv
// ASCON-128 encryption engine for a fixed 1 AD block + 4 plaintext block message,
// one permutation round per clock.
module top_level
  import ascon_pack::*;
(
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         data_valid_i,
  input  logic [63:0]  data_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  output logic         cipher_valid_o,
  output logic         end_o,
  output logic [63:0]  cipher_o,
  output logic [127:0] tag_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_WAIT_AD = 3'd2;
  localparam logic [2:0] S_AD      = 3'd3;
  localparam logic [2:0] S_WAIT_P  = 3'd4;
  localparam logic [2:0] S_PT      = 3'd5;
  localparam logic [2:0] S_FINAL   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]   state;
  ascon_state_t x;
  ascon_state_t rnd_out;
  logic [127:0] key_q;
  logic [3:0]   cnt;
  logic [3:0]   rnd_idx;
  logic [1:0]   blk;
  logic [63:0]  ct;

  // The 6-round schedule reuses the tail of the 12-round constant table.
  assign rnd_idx = (state == S_AD || state == S_PT) ? cnt + 4'(PA_ROUNDS - PB_ROUNDS) : cnt;
  assign ct      = x[0] ^ data_i;

  ascon_round u_round (
    .s_in  (x),
    .rnd   (rnd_idx),
    .s_out (rnd_out)
  );

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state          <= S_IDLE;
      x              <= '0;
      key_q          <= '0;
      cnt            <= '0;
      blk            <= '0;
      cipher_valid_o <= 1'b0;
      end_o          <= 1'b0;
      cipher_o       <= '0;
      tag_o          <= '0;
    end else begin
      cipher_valid_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            x     <= {nonce_i[63:0], nonce_i[127:64], key_i[63:0], key_i[127:64], ASCON_IV};
            key_q <= key_i;
            cnt   <= '0;
            blk   <= '0;
            end_o <= 1'b0;
            state <= S_INIT;
          end
        end
        S_INIT: begin
          x   <= rnd_out;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(PA_ROUNDS - 1)) begin
            x     <= rnd_out ^ {key_q[63:0], key_q[127:64], 192'd0};
            cnt   <= '0;
            state <= S_WAIT_AD;
          end
        end
        S_WAIT_AD: begin
          if (data_valid_i) begin
            x[0]  <= ct;
            cnt   <= '0;
            state <= S_AD;
          end
        end
        S_AD: begin
          x   <= rnd_out;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(PB_ROUNDS - 1)) begin
            x     <= rnd_out ^ {64'd1, 256'd0};
            cnt   <= '0;
            state <= S_WAIT_P;
          end
        end
        S_WAIT_P: begin
          if (data_valid_i) begin
            x[0]           <= ct;
            cipher_o       <= ct;
            cipher_valid_o <= 1'b1;
            cnt            <= '0;
            blk            <= blk + 2'd1;
            state          <= S_PT;
            if (blk == 2'd3) begin
              x[1]  <= x[1] ^ key_q[127:64];
              x[2]  <= x[2] ^ key_q[63:0];
              state <= S_FINAL;
            end
          end
        end
        S_PT: begin
          x   <= rnd_out;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(PB_ROUNDS - 1)) begin
            cnt   <= '0;
            state <= S_WAIT_P;
          end
        end
        S_FINAL: begin
          // Tag is taken from the registered state one cycle after the last round.
          if (cnt == 4'(PA_ROUNDS)) begin
            tag_o <= {x[3] ^ key_q[127:64], x[4] ^ key_q[63:0]};
            end_o <= 1'b1;
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            x   <= rnd_out;
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level: a table-driven ASCON-128 reference produces expected
// ciphertexts and tags; a monitor checks every cipher_valid_o pulse and end_o rise.
module tb_top_level;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_WAIT_AD = 3'd2;
  localparam logic [2:0] S_WAIT_P  = 3'd4;

  localparam logic [4:0] SBOX_T [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam logic [63:0] JUNK = 64'hFFFF_0000_1234_5678;

  logic         clk = 1'b0;
  logic         resetb_i, start_i, data_valid_i;
  logic [63:0]  data_i;
  logic [127:0] key_i, nonce_i;
  logic         cipher_valid_o, end_o;
  logic [63:0]  cipher_o;
  logic [127:0] tag_o;

  top_level dut (
    .clock_i        (clk),
    .resetb_i       (resetb_i),
    .start_i        (start_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .key_i          (key_i),
    .nonce_i        (nonce_i),
    .cipher_valid_o (cipher_valid_o),
    .end_o          (end_o),
    .cipher_o       (cipher_o),
    .tag_o          (tag_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int init_cnt = 0;
  logic [63:0]  exp_c_q [$];
  logic [127:0] exp_t_q [$];

  logic [127:0] vec_k, vec_n;
  logic [63:0]  vec_a;
  logic [63:0]  vec_p  [4];
  logic [63:0]  gold_c [4];
  logic [127:0] gold_t;
  logic [63:0]  m [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h expected %h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  // Reference permutation: rounds first..11, S-box applied column by column via lookup.
  task automatic perm(input int first);
    logic [4:0] col, o;
    for (int i = first; i < 12; i++) begin
      m[2][7:0] = m[2][7:0] ^ 8'(((15 - i) << 4) | i);
      for (int b = 0; b < 64; b++) begin
        col = {m[0][b], m[1][b], m[2][b], m[3][b], m[4][b]};
        o   = SBOX_T[col];
        m[0][b] = o[4]; m[1][b] = o[3]; m[2][b] = o[2]; m[3][b] = o[1]; m[4][b] = o[0];
      end
      m[0] = m[0] ^ ror(m[0], 19) ^ ror(m[0], 28);
      m[1] = m[1] ^ ror(m[1], 61) ^ ror(m[1], 39);
      m[2] = m[2] ^ ror(m[2], 1)  ^ ror(m[2], 6);
      m[3] = m[3] ^ ror(m[3], 10) ^ ror(m[3], 17);
      m[4] = m[4] ^ ror(m[4], 7)  ^ ror(m[4], 41);
    end
  endtask

  task automatic golden();
    m[0] = 64'h80400C0600000000;
    m[1] = vec_k[127:64]; m[2] = vec_k[63:0];
    m[3] = vec_n[127:64]; m[4] = vec_n[63:0];
    perm(0);
    m[3] = m[3] ^ vec_k[127:64]; m[4] = m[4] ^ vec_k[63:0];
    m[0] = m[0] ^ vec_a;
    perm(6);
    m[4] = m[4] ^ 64'd1;
    for (int j = 0; j < 4; j++) begin
      m[0] = m[0] ^ vec_p[j];
      gold_c[j] = m[0];
      if (j < 3) perm(6);
    end
    m[1] = m[1] ^ vec_k[127:64]; m[2] = m[2] ^ vec_k[63:0];
    perm(0);
    gold_t = {m[3] ^ vec_k[127:64], m[4] ^ vec_k[63:0]};
  endtask

  // Monitor: pops the scoreboard on every output event.
  initial begin
    logic       end_prev;
    logic [2:0] st_prev;
    end_prev = 1'b0;
    st_prev  = S_IDLE;
    forever begin
      @(negedge clk);
      if (cipher_valid_o === 1'b1) begin
        if (exp_c_q.size() > 0) check("cipher_o", 128'(cipher_o), 128'(exp_c_q.pop_front()));
        else flag("cipher_valid_o pulse with no block pending");
      end
      if (end_o === 1'b1 && end_prev !== 1'b1) begin
        if (exp_t_q.size() > 0) check("tag_o", tag_o, exp_t_q.pop_front());
        else flag("end_o rose before the last block");
      end
      if (dut.state == S_INIT && st_prev != S_INIT) init_cnt++;
      end_prev = end_o;
      st_prev  = dut.state;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_reset(input string tag);
    check({tag, " cipher_o"},       128'(cipher_o), 128'd0);
    check({tag, " tag_o"},          tag_o, 128'd0);
    check({tag, " end_o"},          128'(end_o), 128'd0);
    check({tag, " cipher_valid_o"}, 128'(cipher_valid_o), 128'd0);
    check({tag, " fsm idle"},       128'(dut.state), 128'(S_IDLE));
    check({tag, " state cleared"},  128'(dut.x == '0), 128'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (dut.state != s && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(dut.state), 128'(s));
  endtask

  task automatic issue(input logic [63:0] d, input int len, input bit noise);
    data_valid_i = 1'b1;
    data_i       = d;
    repeat (len) @(negedge clk);
    data_valid_i = 1'b0;
    if (noise) begin
      // Spurious valids while the permutation is running.
      data_i       = JUNK;
      data_valid_i = 1'b1;
      repeat (2) @(negedge clk);
      data_valid_i = 1'b0;
    end
  endtask

  task automatic run_msg(input int start_len, input int dv_len, input bit noise, input bit abort);
    int lat;
    golden();
    init_cnt = 0;
    @(negedge clk);
    key_i   = vec_k;
    nonce_i = vec_n;
    start_i = 1'b1;
    fork
      begin
        repeat (start_len) @(negedge clk);
        start_i = 1'b0;
      end
    join_none
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("end_o cleared on INIT entry", 128'(end_o), 128'd0);
        key_i   = ~vec_k;
        nonce_i = ~vec_n;
      end
    end while (dut.state != S_WAIT_AD && lat < 40);
    check("start to WAIT_AD latency", 128'(lat), 128'd13);
    issue(vec_a, dv_len, noise);
    wait_state(S_WAIT_P, "WAIT_P after AD");
    for (int j = 0; j < 4; j++) begin
      exp_c_q.push_back(gold_c[j]);
      if (j == 3) exp_t_q.push_back(gold_t);
      issue(vec_p[j], dv_len, noise);
      if (abort && j == 1) begin
        resetb_i = 1'b1;
        @(negedge clk);
        resetb_i = 1'b0;
        check_reset("reset during PT");
        exp_c_q.delete();
        exp_t_q.delete();
        return;
      end
      if (j < 3) wait_state(S_WAIT_P, "WAIT_P after PT");
    end
    lat = dv_len + (noise ? 2 : 0);
    while (end_o !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("last block to end_o latency", 128'(lat), 128'd14);
    @(negedge clk);
    check("cipher_o holds last block", 128'(cipher_o), 128'(gold_c[3]));
    check("end_o held in DONE", 128'(end_o), 128'd1);
    check("single INIT per message", 128'(init_cnt), 128'd1);
    check("no cipher block outstanding", 128'(exp_c_q.size()), 128'd0);
    check("no tag outstanding", 128'(exp_t_q.size()), 128'd0);
  endtask

  initial begin
    resetb_i     = 1'b1;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    key_i        = '0;
    nonce_i      = '0;
    @(negedge clk);
    resetb_i = 1'b0;
    check_reset("after reset");

    vec_k    = 128'h000102030405060708090A0B0C0D0E0F;
    vec_n    = 128'h00112233445566778899AABBCCDDEEFF;
    vec_a    = 64'h3230323380000000;
    vec_p[0] = 64'h436F6E636576657A;
    vec_p[1] = 64'h204153434F4E2065;
    vec_p[2] = 64'h6E2053797374656D;
    vec_p[3] = 64'h566572696C6F6780;

    run_msg(1, 1, 1'b0, 1'b0);   // reference message
    run_msg(20, 1, 1'b0, 1'b0);  // start held, restart from DONE
    run_msg(1, 2, 1'b0, 1'b0);   // 2-cycle data_valid
    run_msg(1, 1, 1'b1, 1'b0);   // spurious valids during rounds
    run_msg(1, 1, 1'b0, 1'b1);   // abort in block 2
    run_msg(1, 1, 1'b0, 1'b0);   // rerun after abort

    vec_k    = 128'h0F0E0D0C0B0A09080706050403020100;
    vec_n    = 128'hFFEEDDCCBBAA99887766554433221100;
    vec_a    = 64'h0123456789ABCDEF;
    vec_p[0] = 64'h1111111111111111;
    vec_p[1] = 64'h0000000000000000;
    vec_p[2] = 64'hFFFFFFFFFFFFFFFF;
    vec_p[3] = 64'hA5A5A5A580000000;
    run_msg(1, 1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
